alu_issue_stage: RTL and testbench

- Decode/issue pipeline stage that sits directly upstream of the RV32I ALU.
- Accepts a fetched instruction with its PC and register-file read data, then decodes the integer ALU classes: OP, OP-IMM, LUI, AUIPC.
- Selects and registers op_1, op_2 and the 4-bit ALU opcode, plus writeback info.
- Uses a valid/ready handshake, a flush input, and optional ALU-result forwarding.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_issue_decode.sv | 75 +++++++
 rtl/alu_issue_stage.sv | 121 ++++++++++++
 tb/tb_alu_issue_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the RV32I ALU issue stage.
// Feature macro used by the top level: ALU_ISSUE_FWD_EN (EX-result forwarding).
package alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_I    = 2'd1,
        IMM_U    = 2'd2
    } imm_type_e;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_ZERO = 2'd1,
        OP1_PC   = 2'd2
    } op1_sel_e;

    typedef struct packed {
        logic [31:0] op_1;
        logic [31:0] op_2;
        logic [3:0]  alu_opcode;
        logic [4:0]  rd_addr;
        logic        wb_en;
        logic        illegal;
    } issue_entry_t;

    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of the RV32I integer ALU classes (OP, OP-IMM, LUI, AUIPC)
// into operand selects, immediate, ALU opcode and legality.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output op1_sel_e    op1_sel,
    output imm_type_e   imm_type,
    output logic [31:0] imm,
    output logic        shift,
    output logic        is_r,
    output logic [3:0]  alu_opcode,
    output logic [4:0]  rd,
    output logic        legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_rs1_field;

    assign opcode           = instr[6:0];
    assign funct3           = instr[14:12];
    assign funct7           = instr[31:25];
    assign rd               = instr[11:7];
    assign unused_rs1_field = ^instr[19:15];

    always_comb begin
        op1_sel    = OP1_ZERO;
        imm_type   = IMM_NONE;
        imm        = '0;
        shift      = 1'b0;
        is_r       = 1'b0;
        alu_opcode = ALU_ADD;
        legal      = 1'b0;
        case (opcode)
            OPC_OP: begin
                op1_sel    = OP1_RS1;
                is_r       = 1'b1;
                shift      = (funct3 == 3'b001) || (funct3 == 3'b101);
                alu_opcode = {instr[30], funct3};
                legal      = (funct7 == 7'b0000000) ||
                             ((funct7 == 7'b0100000) &&
                              ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                op1_sel  = OP1_RS1;
                imm_type = IMM_I;
                imm      = imm_i(instr);
                shift    = (funct3 == 3'b001) || (funct3 == 3'b101);
                legal    = 1'b1;
                // instr[30] only selects SRAI; elsewhere it is immediate data
                case (funct3)
                    3'b101:  alu_opcode = {instr[30], 3'b101};
                    3'b001:  alu_opcode = ALU_SLL;
                    default: alu_opcode = {1'b0, funct3};
                endcase
            end
            OPC_LUI: begin
                op1_sel  = OP1_ZERO;
                imm_type = IMM_U;
                imm      = {instr[31:12], 12'b0};
                legal    = 1'b1;
            end
            OPC_AUIPC: begin
                op1_sel  = OP1_PC;
                imm_type = IMM_U;
                imm      = {instr[31:12], 12'b0};
                legal    = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage ahead of the RV32I ALU: single-entry valid/ready register
// with flush. Define ALU_ISSUE_FWD_EN to add EX-result forwarding ports.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit NOP_ON_ILLEGAL = 1'b1
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] rs1_data_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic            flush_in,
    output logic            valid_out,
    input  logic            ready_in,
    output logic [XLEN-1:0] op_1_out,
    output logic [XLEN-1:0] op_2_out,
    output logic [3:0]      alu_opcode_out,
    output logic [4:0]      rd_addr_out,
    output logic            wb_en_out,
    output logic            illegal_out
`ifdef ALU_ISSUE_FWD_EN
    ,
    input  logic            fwd_valid_in,
    input  logic [4:0]      fwd_rd_in,
    input  logic [XLEN-1:0] fwd_data_in
`endif
);

    op1_sel_e     dec_op1_sel;
    imm_type_e    dec_imm_type;
    logic [31:0]  dec_imm;
    logic         dec_shift;
    logic         dec_is_r;
    logic [3:0]   dec_alu_opcode;
    logic [4:0]   dec_rd;
    logic         dec_legal;

    logic         valid_q, valid_d;
    issue_entry_t entry_q, entry_d;
    issue_entry_t new_entry;
    logic [31:0]  rs1_val, rs2_val, op_2_raw;
    logic         accept;

    alu_issue_decode u_decode (
        .instr      (instr_in),
        .op1_sel    (dec_op1_sel),
        .imm_type   (dec_imm_type),
        .imm        (dec_imm),
        .shift      (dec_shift),
        .is_r       (dec_is_r),
        .alu_opcode (dec_alu_opcode),
        .rd         (dec_rd),
        .legal      (dec_legal)
    );

    assign ready_out = !valid_q || ready_in;
    assign accept    = valid_in && ready_out;

    always_comb begin
        rs1_val = rs1_data_in;
        rs2_val = rs2_data_in;
`ifdef ALU_ISSUE_FWD_EN
        if (fwd_valid_in && (fwd_rd_in != 5'd0) && (fwd_rd_in == instr_in[19:15]))
            rs1_val = fwd_data_in;
        if (dec_is_r && fwd_valid_in && (fwd_rd_in != 5'd0) && (fwd_rd_in == instr_in[24:20]))
            rs2_val = fwd_data_in;
`endif
        op_2_raw = (dec_imm_type == IMM_NONE) ? rs2_val : dec_imm;

        new_entry         = '0;
        new_entry.rd_addr = dec_rd;
        if (dec_legal) begin
            case (dec_op1_sel)
                OP1_RS1: new_entry.op_1 = rs1_val;
                OP1_PC:  new_entry.op_1 = pc_in;
                default: new_entry.op_1 = '0;
            endcase
            // The ALU shifts by the whole operand, so only the 5-bit shamt may pass
            new_entry.op_2       = dec_shift ? {27'b0, op_2_raw[4:0]} : op_2_raw;
            new_entry.alu_opcode = dec_alu_opcode;
            new_entry.wb_en      = (dec_rd != 5'd0);
        end else begin
            new_entry.illegal = NOP_ON_ILLEGAL;
        end

        valid_d = valid_q;
        entry_d = entry_q;
        if (flush_in) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            entry_d = new_entry;
        end else if (ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_out      = valid_q;
    assign op_1_out       = entry_q.op_1;
    assign op_2_out       = entry_q.op_2;
    assign alu_opcode_out = entry_q.alu_opcode;
    assign rd_addr_out    = entry_q.rd_addr;
    assign wb_en_out      = entry_q.wb_en;
    assign illegal_out    = entry_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a per-cycle behavioural model comparison.
module tb_alu_issue_stage;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [31:0] instr_in = '0;
    logic [31:0] pc_in = '0;
    logic [31:0] rs1_data_in = '0;
    logic [31:0] rs2_data_in = '0;
    logic        flush_in = 1'b0;
    logic        valid_out;
    logic        ready_in = 1'b1;
    logic [31:0] op_1_out;
    logic [31:0] op_2_out;
    logic [3:0]  alu_opcode_out;
    logic [4:0]  rd_addr_out;
    logic        wb_en_out;
    logic        illegal_out;
`ifdef ALU_ISSUE_FWD_EN
    logic        fwd_valid_in = 1'b0;
    logic [4:0]  fwd_rd_in = '0;
    logic [31:0] fwd_data_in = '0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    alu_issue_stage dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .instr_in       (instr_in),
        .pc_in          (pc_in),
        .rs1_data_in    (rs1_data_in),
        .rs2_data_in    (rs2_data_in),
        .flush_in       (flush_in),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .op_1_out       (op_1_out),
        .op_2_out       (op_2_out),
        .alu_opcode_out (alu_opcode_out),
        .rd_addr_out    (rd_addr_out),
        .wb_en_out      (wb_en_out),
        .illegal_out    (illegal_out)
`ifdef ALU_ISSUE_FWD_EN
        ,
        .fwd_valid_in   (fwd_valid_in),
        .fwd_rd_in      (fwd_rd_in),
        .fwd_data_in    (fwd_data_in)
`endif
    );

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  opc;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected issue result computed straight from the instruction-set rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic fv, input logic [4:0] frd,
                                   input logic [31:0] fd);
        exp_t        e;
        logic [31:0] a, b, imm;
        int          f3, f7, sub;
        bit          ok;
        e   = '0;
        e.rd = ins[11:7];
        f3  = int'(ins[14:12]);
        f7  = int'(ins[31:25]);
        sub = ins[30] ? 8 : 0;
        ok  = 1'b1;
        a   = (fv && frd != 0 && frd == ins[19:15]) ? fd : r1;
        b   = (fv && frd != 0 && frd == ins[24:20]) ? fd : r2;
        imm = 32'(signed'(ins) >>> 20);
        case (ins[6:0])
            7'h33: begin
                ok    = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                e.op1 = a;
                e.op2 = (f3 == 1 || f3 == 5) ? (b % 32) : b;
                e.opc = 4'(f3 + sub);
            end
            7'h13: begin
                e.op1 = a;
                e.op2 = (f3 == 1 || f3 == 5) ? (imm % 32) : imm;
                e.opc = (f3 == 5) ? 4'(5 + sub) : 4'(f3);
            end
            7'h37: begin
                e.op1 = 32'd0;
                e.op2 = ins & 32'hFFFFF000;
            end
            7'h17: begin
                e.op1 = pc;
                e.op2 = ins & 32'hFFFFF000;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.op1 = 32'd0;
            e.op2 = 32'd0;
            e.opc = 4'd0;
            e.wb  = 1'b0;
            e.ill = 1'b1;
        end else begin
            e.wb = (ins[11:7] != 5'd0);
        end
        return e;
    endfunction

    logic m_valid;
    exp_t m_e;

    always @(posedge clk_in) begin
        if (rst_in) begin
            m_valid <= 1'b0;
            m_e     <= '0;
        end else if (flush_in) begin
            m_valid <= 1'b0;
        end else if (valid_in && (!m_valid || ready_in)) begin
            m_valid <= 1'b1;
`ifdef ALU_ISSUE_FWD_EN
            m_e <= model(instr_in, pc_in, rs1_data_in, rs2_data_in, fwd_valid_in, fwd_rd_in, fwd_data_in);
`else
            m_e <= model(instr_in, pc_in, rs1_data_in, rs2_data_in, 1'b0, 5'd0, 32'd0);
`endif
        end else if (ready_in) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk_in) begin
        if (!rst_in) begin
            chk("m_valid", {31'b0, valid_out}, {31'b0, m_valid});
            chk("m_ready", {31'b0, ready_out}, {31'b0, (!m_valid || ready_in)});
            chk("m_op1", op_1_out, m_e.op1);
            chk("m_op2", op_2_out, m_e.op2);
            chk("m_opc", {28'b0, alu_opcode_out}, {28'b0, m_e.opc});
            chk("m_wb", {31'b0, wb_en_out}, {31'b0, m_e.wb});
            chk("m_ill", {31'b0, illegal_out}, {31'b0, m_e.ill});
            if (!m_e.ill)
                chk("m_rd", {27'b0, rd_addr_out}, {27'b0, m_e.rd});
        end
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        valid_in    = 1'b1;
        instr_in    = ins;
        pc_in       = pc;
        rs1_data_in = r1;
        rs2_data_in = r2;
        cyc();
        $display("txn instr=%h pc=%h -> valid=%0d op1=%h op2=%h opc=%h rd=%0d wb=%0d ill=%0d",
                 ins, pc, valid_out, op_1_out, op_2_out, alu_opcode_out, rd_addr_out,
                 wb_en_out, illegal_out);
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_valid", {31'b0, valid_out}, 32'd0);
        chk("rst_op1", op_1_out, 32'd0);
        chk("rst_op2", op_2_out, 32'd0);
        chk("rst_opc", {28'b0, alu_opcode_out}, 32'd0);
        chk("rst_rd", {27'b0, rd_addr_out}, 32'd0);
        chk("rst_wb", {31'b0, wb_en_out}, 32'd0);
        chk("rst_ill", {31'b0, illegal_out}, 32'd0);
        rst_in = 1'b0;

        issue(32'hFFF08293, 32'h0, 32'h10, 32'h0);          // ADDI x5,x1,-1
        chk("addi_valid", {31'b0, valid_out}, 32'd1);
        chk("addi_op1", op_1_out, 32'h10);
        chk("addi_op2", op_2_out, 32'hFFFFFFFF);
        chk("addi_opc", {28'b0, alu_opcode_out}, 32'h0);
        chk("addi_rd", {27'b0, rd_addr_out}, 32'd5);
        chk("addi_wb", {31'b0, wb_en_out}, 32'd1);

        issue(32'h40725193, 32'h4, 32'h80000000, 32'h0);    // SRAI x3,x4,7
        chk("srai_op2", op_2_out, 32'h7);
        chk("srai_opc", {28'b0, alu_opcode_out}, 32'hD);

        issue(32'h00839333, 32'h8, 32'h1, 32'hFFFFFFE3);    // SLL x6,x7,x8
        chk("sll_op2", op_2_out, 32'h3);
        chk("sll_opc", {28'b0, alu_opcode_out}, 32'h1);

        issue(32'h40008093, 32'hC, 32'h5, 32'h0);           // ADDI x1,x1,0x400
        chk("addi30_opc", {28'b0, alu_opcode_out}, 32'h0);
        chk("addi30_op2", op_2_out, 32'h400);

        issue(32'h002084B3, 32'h10, 32'h11, 32'h22);        // ADD x9,x1,x2
        chk("stall_first_op1", op_1_out, 32'h11);
        instr_in    = 32'h40418533;                         // SUB x10,x3,x4
        rs1_data_in = 32'h33;
        rs2_data_in = 32'h44;
        ready_in    = 1'b0;
        #1;
        chk("stall_ready", {31'b0, ready_out}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_hold_op1", op_1_out, 32'h11);
            chk("stall_hold_valid", {31'b0, valid_out}, 32'd1);
        end
        ready_in = 1'b1;
        cyc();
        chk("release_op1", op_1_out, 32'h33);
        chk("release_op2", op_2_out, 32'h44);
        chk("release_opc", {28'b0, alu_opcode_out}, 32'h8);
        chk("release_rd", {27'b0, rd_addr_out}, 32'd10);
        valid_in = 1'b0;
        cyc();
        chk("drain_valid", {31'b0, valid_out}, 32'd0);
        chk("drain_op1", op_1_out, 32'h33);

        flush_in = 1'b1;
        issue(32'h00001097, 32'h100, 32'h0, 32'h0);         // AUIPC x1,1 flushed
        chk("flush_valid", {31'b0, valid_out}, 32'd0);
        flush_in = 1'b0;
        issue(32'h00001097, 32'h100, 32'h0, 32'h0);
        chk("auipc_op1", op_1_out, 32'h100);
        chk("auipc_op2", op_2_out, 32'h1000);
        issue(32'h123453B7, 32'h104, 32'h55, 32'h66);       // LUI x7,0x12345
        chk("lui_op1", op_1_out, 32'h0);
        chk("lui_op2", op_2_out, 32'h12345000);
        chk("lui_rd", {27'b0, rd_addr_out}, 32'd7);

        issue(32'h0000007F, 32'h108, 32'h1, 32'h2);
        chk("ill_valid", {31'b0, valid_out}, 32'd1);
        chk("ill_flag", {31'b0, illegal_out}, 32'd1);
        chk("ill_wb", {31'b0, wb_en_out}, 32'd0);
        issue(32'h40209033, 32'h10C, 32'h1, 32'h2);         // funct7=0100000 with SLL
        chk("ill_f7_flag", {31'b0, illegal_out}, 32'd1);
        chk("ill_f7_op1", op_1_out, 32'h0);
        issue(32'h00208033, 32'h110, 32'h1, 32'h2);         // ADD x0,x1,x2
        chk("x0_wb", {31'b0, wb_en_out}, 32'd0);
        chk("x0_ill", {31'b0, illegal_out}, 32'd0);

`ifdef ALU_ISSUE_FWD_EN
        fwd_valid_in = 1'b1;
        fwd_rd_in    = 5'd2;
        fwd_data_in  = 32'hDEAD;
        issue(32'h002100B3, 32'h114, 32'h1, 32'h2);         // ADD x1,x2,x2
        chk("fwd_op1", op_1_out, 32'hDEAD);
        chk("fwd_op2", op_2_out, 32'hDEAD);
        fwd_rd_in = 5'd0;
        issue(32'h002100B3, 32'h118, 32'h1, 32'h2);
        chk("nofwd_op1", op_1_out, 32'h1);
        chk("nofwd_op2", op_2_out, 32'h2);
        fwd_valid_in = 1'b0;
`endif

        valid_in = 1'b0;
        cyc();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
